// File: rtl/jtag_mem_dr_pkg.sv
// Shared types for the JTAG memory-access data register: op codes, bus FSM states,
// and the status-bit layout of the captured frame.
package jtag_mem_dr_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REQ      = 2'b01,
        WAIT_RSP = 2'b10
    } state_e;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_ERR  = 1;

    // Packs busy/err into the two status bits at the bottom of the captured frame.
    function automatic logic [1:0] status_bits(input logic busy, input logic err);
        logic [1:0] s;
        s            = 2'b00;
        s[STAT_BUSY] = busy;
        s[STAT_ERR]  = err;
        return s;
    endfunction

endpackage

// File: rtl/jtag_mem_dr_bus_fsm.sv
// Bus-side engine: access FSM, timeout counter, address/data/status registers.
// Optional feature: JTAG_MEM_DR_AUTOINC_EN (address post-increment after clean completion).
module jtag_mem_dr_bus_fsm
    import jtag_mem_dr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned TIMEOUT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  start_we,
    input  logic                  load_addr,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [DATA_WIDTH-1:0] start_wdata,
    input  logic                  overrun,
    input  logic                  clr_err,
    input  logic                  gnt,
    input  logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  err_in,
    output logic                  req,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata_q,
    output logic                  err_q,
    output logic                  busy
);

    localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE   = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = {TIMEOUT_WIDTH{1'b1}};
`ifdef JTAG_MEM_DR_AUTOINC_EN
    localparam logic [ADDR_WIDTH-1:0]    ADDR_INC = ADDR_WIDTH'(DATA_WIDTH / 8);
`endif

    state_e                   state_r;
    logic [TIMEOUT_WIDTH-1:0] cnt_r;
    logic                     req_r;
    logic                     we_r;
    logic [ADDR_WIDTH-1:0]    addr_r;
    logic [DATA_WIDTH-1:0]    wdata_r;
    logic [DATA_WIDTH-1:0]    rdata_r;
    logic                     err_r;

    logic [TIMEOUT_WIDTH-1:0] cnt_inc_s;
    logic                     timeout_s;
    logic                     to_err_s;
    logic                     rsp_err_s;

    // Timeout detection and error events raised by the current state.
    always_comb begin
        cnt_inc_s = cnt_r + TO_ONE;
        timeout_s = (cnt_inc_s == TO_LIMIT);
        to_err_s  = 1'b0;
        rsp_err_s = 1'b0;
        case (state_r)
            REQ: begin
                to_err_s = !gnt && timeout_s;
            end
            WAIT_RSP: begin
                to_err_s  = !rvalid && timeout_s;
                rsp_err_s = rvalid && err_in;
            end
            default: begin
                to_err_s  = 1'b0;
                rsp_err_s = 1'b0;
            end
        endcase
    end

    // Access FSM with registered bus outputs; a grant on the timeout edge wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= REQ;
                        cnt_r   <= '0;
                        req_r   <= 1'b1;
                        we_r    <= start_we;
                        if (load_addr) begin
                            addr_r <= start_addr;
                        end
                        if (start_we) begin
                            wdata_r <= start_wdata;
                        end
                    end
                end
                REQ: begin
                    if (gnt) begin
                        state_r <= WAIT_RSP;
                        req_r   <= 1'b0;
                        cnt_r   <= timeout_s ? cnt_r : cnt_inc_s;
                    end else if (timeout_s) begin
                        state_r <= IDLE;
                        req_r   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                WAIT_RSP: begin
                    if (rvalid) begin
                        state_r <= IDLE;
                        if (!we_r) begin
                            rdata_r <= rdata;
                        end
`ifdef JTAG_MEM_DR_AUTOINC_EN
                        if (!err_in) begin
                            addr_r <= addr_r + ADDR_INC;
                        end
`endif
                    end else if (timeout_s) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag; a new error event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (overrun || to_err_s || rsp_err_s) begin
            err_r <= 1'b1;
        end else if (clr_err) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign req     = req_r;
    assign we      = we_r;
    assign addr    = addr_r;
    assign wdata   = wdata_r;
    assign rdata_q = rdata_r;
    assign err_q   = err_r;
    assign busy    = (state_r != IDLE);

endmodule

// File: rtl/jtag_mem_dr.sv
// JTAG data register turning DR scans into single memory-bus accesses (all on TCK).
// Optional feature: JTAG_MEM_DR_AUTOINC_EN (all-ones address field keeps auto-incremented address).
module jtag_mem_dr
    import jtag_mem_dr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned TIMEOUT_WIDTH = 8
) (
    input  logic                  tck_i,
    input  logic                  rst_ni,
    input  logic                  shift_dr_i,
    input  logic                  capture_dr_i,
    input  logic                  update_dr_i,
    input  logic                  sel_i,
    input  logic                  scan_in_i,
    output logic                  scan_out_o,
    output logic                  req_o,
    input  logic                  gnt_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic                  rvalid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  err_i
);

    localparam int unsigned L = 2 + ADDR_WIDTH + DATA_WIDTH;

    logic [L-1:0]          sr_r;
    op_e                   op_s;
    logic [ADDR_WIDTH-1:0] frame_addr_s;
    logic [DATA_WIDTH-1:0] frame_data_s;
    logic                  start_s;
    logic                  start_we_s;
    logic                  overrun_s;
    logic                  clr_s;
    logic                  load_addr_s;
    logic                  busy_s;
    logic                  err_s;
    logic [DATA_WIDTH-1:0] rdata_q_s;

    assign op_s         = op_e'(sr_r[1:0]);
    assign frame_addr_s = sr_r[ADDR_WIDTH+1:2];
    assign frame_data_s = sr_r[L-1:ADDR_WIDTH+2];

    // Update decode: launch an access when idle, flag an overrun when busy.
    always_comb begin
        start_s    = 1'b0;
        start_we_s = 1'b0;
        overrun_s  = 1'b0;
        clr_s      = 1'b0;
        if (update_dr_i && sel_i) begin
            case (op_s)
                OP_READ, OP_WRITE: begin
                    start_we_s = (op_s == OP_WRITE);
                    if (busy_s) begin
                        overrun_s = 1'b1;
                    end else begin
                        start_s = 1'b1;
                    end
                end
                OP_CLR: begin
                    clr_s = 1'b1;
                end
                default: begin
                    clr_s = 1'b0;
                end
            endcase
        end else begin
            start_s = 1'b0;
        end
    end

`ifdef JTAG_MEM_DR_AUTOINC_EN
    assign load_addr_s = (frame_addr_s != {ADDR_WIDTH{1'b1}});
`else
    assign load_addr_s = 1'b1;
`endif

    // Capture/shift register; holds whenever this DR is not selected.
    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_r <= '0;
        end else if (sel_i && capture_dr_i) begin
            sr_r <= {rdata_q_s, addr_o, status_bits(busy_s, err_s)};
        end else if (sel_i && shift_dr_i) begin
            sr_r <= {scan_in_i, sr_r[L-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign scan_out_o = sr_r[0];

    jtag_mem_dr_bus_fsm #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_bus_fsm (
        .clk        (tck_i),
        .rst_n      (rst_ni),
        .start      (start_s),
        .start_we   (start_we_s),
        .load_addr  (load_addr_s),
        .start_addr (frame_addr_s),
        .start_wdata(frame_data_s),
        .overrun    (overrun_s),
        .clr_err    (clr_s),
        .gnt        (gnt_i),
        .rvalid     (rvalid_i),
        .rdata      (rdata_i),
        .err_in     (err_i),
        .req        (req_o),
        .we         (we_o),
        .addr       (addr_o),
        .wdata      (wdata_o),
        .rdata_q    (rdata_q_s),
        .err_q      (err_s),
        .busy       (busy_s)
    );

endmodule

// File: tb/tb_jtag_mem_dr.sv
// Directed self-checking bench for jtag_mem_dr; expectations follow JTAG_MEM_DR_AUTOINC_EN when defined.
module tb_jtag_mem_dr;

    localparam int L = 66;

    logic        tck_i = 1'b0;
    logic        rst_ni;
    logic        shift_dr_i, capture_dr_i, update_dr_i, sel_i, scan_in_i;
    logic        scan_out_o, req_o, gnt_i, we_o, rvalid_i, err_i;
    logic [31:0] addr_o, wdata_o, rdata_i;

    int checks = 0;
    int errors = 0;

`ifdef JTAG_MEM_DR_AUTOINC_EN
    localparam logic [31:0] EXP_WR_ADDR  = 32'h1000_0004;
    localparam logic [31:0] EXP_RD_ADDR  = 32'h0000_0024;
    localparam logic [31:0] EXP_OV_ADDR  = 32'h0000_0084;
    localparam logic [31:0] EXP_ONES_REQ = 32'h0000_0104;
`else
    localparam logic [31:0] EXP_WR_ADDR  = 32'h1000_0000;
    localparam logic [31:0] EXP_RD_ADDR  = 32'h0000_0020;
    localparam logic [31:0] EXP_OV_ADDR  = 32'h0000_0080;
    localparam logic [31:0] EXP_ONES_REQ = 32'hFFFF_FFFF;
`endif

    jtag_mem_dr #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_WIDTH(4)) dut (
        .tck_i       (tck_i),
        .rst_ni      (rst_ni),
        .shift_dr_i  (shift_dr_i),
        .capture_dr_i(capture_dr_i),
        .update_dr_i (update_dr_i),
        .sel_i       (sel_i),
        .scan_in_i   (scan_in_i),
        .scan_out_o  (scan_out_o),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rvalid_i    (rvalid_i),
        .rdata_i     (rdata_i),
        .err_i       (err_i)
    );

    always #5 tck_i = ~tck_i;

    function automatic logic [L-1:0] frame(input logic [31:0] data, input logic [31:0] addr,
                                           input logic [1:0] op);
        return {data, addr, op};
    endfunction

    // Capture, shift L bits, then update; returns at the negedge after the update edge.
    task automatic scan_dr(input logic [L-1:0] din, output logic [L-1:0] dout);
        @(negedge tck_i);
        capture_dr_i = 1'b1;
        @(negedge tck_i);
        capture_dr_i = 1'b0;
        shift_dr_i   = 1'b1;
        for (int i = 0; i < L; i++) begin
            dout[i]   = scan_out_o;
            scan_in_i = din[i];
            @(negedge tck_i);
        end
        shift_dr_i  = 1'b0;
        update_dr_i = 1'b1;
        @(negedge tck_i);
        update_dr_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [L-1:0] d;
        rst_ni = 1'b0;
        shift_dr_i = 1'b0; capture_dr_i = 1'b0; update_dr_i = 1'b0; sel_i = 1'b1;
        scan_in_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = 32'h0;
        repeat (3) @(negedge tck_i);
        checks++;
        if ({req_o, we_o, scan_out_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b required 000", {req_o, we_o, scan_out_o});
        end
        checks++;
        if ({addr_o, wdata_o} !== 64'h0) begin
            errors++; $display("FAIL reset_bus: got %h required 0", {addr_o, wdata_o});
        end
        rst_ni = 1'b1;
        scan_dr(frame(32'h0, 32'h0, 2'b00), d);
        checks++;
        if (d !== {L{1'b0}}) begin
            errors++; $display("FAIL reset_scan: got %h required 0", d);
        end
        checks++;
        if (req_o !== 1'b0) begin
            errors++; $display("FAIL reset_nop_req: got %b required 0", req_o);
        end
    endtask

    task automatic test_write();
        logic [L-1:0] d;
        scan_dr(frame(32'hDEAD_BEEF, 32'h1000_0000, 2'b10), d);
        checks++;
        if ({req_o, we_o, addr_o, wdata_o} !== {1'b1, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL write_req: got req=%b we=%b addr=%h wdata=%h required 1 1 10000000 deadbeef",
                     req_o, we_o, addr_o, wdata_o);
        end
        gnt_i = 1'b1;
        @(negedge tck_i);
        gnt_i = 1'b0; rvalid_i = 1'b1;
        checks++;
        if (req_o !== 1'b0) begin
            errors++; $display("FAIL write_req_drop: got %b required 0", req_o);
        end
        @(negedge tck_i);
        rvalid_i = 1'b0;
        scan_dr(frame(32'h0, 32'h0, 2'b00), d);
        checks++;
        if (d[1:0] !== 2'b00) begin
            errors++; $display("FAIL write_status: got %b required 00", d[1:0]);
        end
        checks++;
        if (d[33:2] !== EXP_WR_ADDR || d[65:34] !== 32'h0) begin
            errors++; $display("FAIL write_frame: got addr=%h data=%h required %h 0", d[33:2], d[65:34], EXP_WR_ADDR);
        end
    endtask

    task automatic test_read();
        logic [L-1:0] d;
        scan_dr(frame(32'h0, 32'h0000_0020, 2'b01), d);
        checks++;
        if ({req_o, we_o, addr_o} !== {1'b1, 1'b0, 32'h20}) begin
            errors++; $display("FAIL read_req: got req=%b we=%b addr=%h required 1 0 20", req_o, we_o, addr_o);
        end
        gnt_i = 1'b1;
        @(negedge tck_i);
        gnt_i = 1'b0;
        @(negedge tck_i);
        rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
        @(negedge tck_i);
        rvalid_i = 1'b0; rdata_i = 32'h0;
        scan_dr(frame(32'h0, 32'h0, 2'b00), d);
        checks++;
        if (d !== {32'h1234_5678, EXP_RD_ADDR, 2'b00}) begin
            errors++; $display("FAIL read_capture: got %h required %h", d, {32'h1234_5678, EXP_RD_ADDR, 2'b00});
        end
    endtask

    task automatic test_timeout();
        logic [L-1:0] d;
        int cnt;
        scan_dr(frame(32'h0, 32'h0000_0040, 2'b01), d);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (req_o !== 1'b1) break;
            cnt++;
            @(negedge tck_i);
        end
        checks++;
        if (cnt != 15) begin
            errors++; $display("FAIL timeout_len: got %0d cycles required 15", cnt);
        end
        scan_dr(frame(32'h0, 32'h0, 2'b11), d);
        checks++;
        if (d[33:0] !== {32'h40, 2'b10}) begin
            errors++; $display("FAIL timeout_status: got addr=%h st=%b required 40 10", d[33:2], d[1:0]);
        end
        scan_dr(frame(32'h0, 32'h0, 2'b00), d);
        checks++;
        if (d[1:0] !== 2'b00) begin
            errors++; $display("FAIL clr_status: got %b required 00", d[1:0]);
        end
    endtask

    task automatic test_overrun();
        logic [L-1:0] d;
        scan_dr(frame(32'h0, 32'h0000_0080, 2'b01), d);
        gnt_i = 1'b1;
        @(negedge tck_i);
        gnt_i = 1'b0; update_dr_i = 1'b1;
        @(negedge tck_i);
        update_dr_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hAABB_CCDD;
        checks++;
        if (req_o !== 1'b0) begin
            errors++; $display("FAIL overrun_req: got %b required 0", req_o);
        end
        @(negedge tck_i);
        rvalid_i = 1'b0; rdata_i = 32'h0;
        @(negedge tck_i);
        checks++;
        if (req_o !== 1'b0) begin
            errors++; $display("FAIL overrun_no_second: got %b required 0", req_o);
        end
        scan_dr(frame(32'h0, 32'h0, 2'b11), d);
        checks++;
        if (d !== {32'hAABB_CCDD, EXP_OV_ADDR, 2'b10}) begin
            errors++; $display("FAIL overrun_capture: got %h required %h", d, {32'hAABB_CCDD, EXP_OV_ADDR, 2'b10});
        end
    endtask

    task automatic test_async_reset();
        logic [L-1:0] d;
        scan_dr(frame(32'h0, 32'h0000_0100, 2'b01), d);
        checks++;
        if (req_o !== 1'b1) begin
            errors++; $display("FAIL arst_pre_req: got %b required 1", req_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_o, addr_o} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL arst_req: got req=%b addr=%h required 0 0", req_o, addr_o);
        end
        @(negedge tck_i);
        rst_ni = 1'b1;
        scan_dr(frame(32'h0, 32'h0, 2'b00), d);
        checks++;
        if (d !== {L{1'b0}}) begin
            errors++; $display("FAIL arst_capture: got %h required 0", d);
        end
    endtask

    task automatic test_autoinc();
        logic [L-1:0] d;
        scan_dr(frame(32'h0, 32'h0000_0100, 2'b01), d);
        gnt_i = 1'b1;
        @(negedge tck_i);
        gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1111_2222;
        @(negedge tck_i);
        rvalid_i = 1'b0;
        scan_dr(frame(32'h0, 32'hFFFF_FFFF, 2'b01), d);
        checks++;
        if (d[65:34] !== 32'h1111_2222) begin
            errors++; $display("FAIL burst_first_data: got %h required 11112222", d[65:34]);
        end
        checks++;
        if ({req_o, addr_o} !== {1'b1, EXP_ONES_REQ}) begin
            errors++; $display("FAIL burst_addr: got req=%b addr=%h required 1 %h", req_o, addr_o, EXP_ONES_REQ);
        end
        gnt_i = 1'b1;
        @(negedge tck_i);
        gnt_i = 1'b0; rvalid_i = 1'b1; err_i = 1'b1; rdata_i = 32'h3333_4444;
        @(negedge tck_i);
        rvalid_i = 1'b0; err_i = 1'b0;
        scan_dr(frame(32'h0, 32'h0, 2'b11), d);
        checks++;
        if (d !== {32'h3333_4444, EXP_ONES_REQ, 2'b10}) begin
            errors++; $display("FAIL bus_err_capture: got %h required %h", d, {32'h3333_4444, EXP_ONES_REQ, 2'b10});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_overrun();
        test_async_reset();
        test_autoinc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_mem_dr.md
# jtag_mem_dr

JTAG data register that turns DR scans into single memory-bus accesses. It sits directly downstream of the TAP controller: it consumes the TAP's shift/capture/update strobes, its memory-select line and the TDI pass-through, and returns its serial output to the TAP's TDO multiplexer. All logic runs on TCK. Bus-side clock-domain crossing is handled by a separate block.

## Interface
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width (multiple of 8).
- TIMEOUT_WIDTH, 8, width of the access timeout counter; limit is 2^TIMEOUT_WIDTH-1 TCK cycles.
- tck_i  in  1  JTAG test clock; the only clock.
- rst_ni  in  1  asynchronous, active-low reset.
- shift_dr_i / capture_dr_i / update_dr_i  in  1 each  TAP state strobes, one TCK period each.
- sel_i  in  1  this DR selected by the latched IR.
- scan_in_i  in  1  serial data in (TDI).
- scan_out_o  out  1  serial data out, equal to sr[0].
- req_o  out  1  bus request.
- gnt_i  in  1  bus grant.
- we_o  out  1  write enable.
- addr_o  out  ADDR_WIDTH  access address.
- wdata_o  out  DATA_WIDTH  write data.
- rvalid_i  in  1  response valid.
- rdata_i  in  DATA_WIDTH  read data.
- err_i  in  1  bus error, qualified by rvalid_i.

## Operation
- Shift register sr has length L = 2+ADDR_WIDTH+DATA_WIDTH. Frame layout, LSB first: sr[1:0]=op/status, sr[ADDR_WIDTH+1:2]=addr, top DATA_WIDTH bits=data.
- Capture (capture_dr_i & sel_i): sr <= {rdata_q, addr_q, err_q, busy}.
- Shift (shift_dr_i & sel_i): sr <= {scan_in_i, sr[L-1:1]}.
- Update (update_dr_i & sel_i) decodes op = sr[1:0]:
  - 00 NOP: no action.
  - 01 READ: load addr_q from frame; start a read.
  - 10 WRITE: load addr_q and wdata_q from frame; start a write.
  - 11 CLR: clear err_q.
- Overrun: a READ or WRITE update while busy is ignored and sets err_q.
- FSM states:
  - IDLE: on a valid READ/WRITE update, go to REQ.
  - REQ: req_o=1. On gnt_i, go to WAIT_RSP.
  - WAIT_RSP: on rvalid_i, latch rdata_q (reads only); set err_q if err_i; go to IDLE.
- busy = (state != IDLE).
- Timeout: the counter clears on entering REQ and counts in REQ and WAIT_RSP. At the limit: set err_q, drop req_o, return to IDLE.
- err_q is sticky. It is cleared only by CLR or rst_ni; TAP logic reset does not clear it.
- Debugger obligation: keep TCK running (Run-Test/Idle) until completion. The FSM advances only on TCK edges.

## Timing
- Reset values: req_o=0, we_o=0, addr_o=0, wdata_o=0, sr=0, so scan_out_o=0. Also rdata_q=0, err_q=0, state=IDLE.
- Update edge N: req_o, we_o, addr_o and wdata_o are registered and valid from edge N+1. They are held stable until the grant edge.
- Grant is accepted on the edge where req_o & gnt_i; req_o falls on the next edge.
- rvalid_i is ignored in REQ. The earliest response is one cycle after grant.
- Minimum access takes 3 TCK edges from update to IDLE.
- Capture in the same cycle as completion sees the pre-completion state: busy=1 and old rdata.
- rst_ni asserted mid-access: req_o drops immediately (asynchronously); the in-flight access is abandoned.
- sel_i low: sr holds; the FSM keeps running.

## Configuration
- JTAG_MEM_DR_AUTOINC_EN
  - Defined: after each completed access without error, addr_q += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH. A READ/WRITE frame whose addr field is all ones keeps the incremented addr_q instead of loading it, allowing burst streaming.
  - Undefined: addr_q changes only on update, and all-ones is an ordinary address.

## Structure
- Package jtag_mem_dr_pkg holds:
  - op encodings: NOP, READ, WRITE, CLR.
  - FSM state enum: IDLE, REQ, WAIT_RSP.
  - status bit indices: BUSY=0, ERR=1.
- Sub-module jtag_mem_dr_bus_fsm holds the FSM, timeout counter and bus-side registers. The shift register and op decode stay in the top.

## Test plan
- Reset, then capture and 66 shifts -> scan_out_o stream all zeros; req_o=0.
- WRITE addr=0x1000_0000 data=0xDEAD_BEEF; gnt_i one cycle after req_o; rvalid_i the next cycle -> one request with we_o=1 and exact values; next capture shows status=00.
- READ addr=0x20; rdata_i=0x1234_5678 with rvalid_i two cycles after grant -> capture shifts out status 00, addr 0x20, data 0x1234_5678.
- gnt_i held low (TIMEOUT_WIDTH=4) -> req_o drops after 15 cycles; status=10; CLR -> status=00.
- Second READ update while in WAIT_RSP -> ignored, first access completes, status=10. Assert rst_ni mid-REQ -> req_o=0 immediately.
- With JTAG_MEM_DR_AUTOINC_EN: READ at 0x100, then READ with addr all ones -> second access at 0x104. Without the macro -> access at 0xFFFF_FFFF.
